div_softmax_pipe: RTL and testbench

Parametrised successor of the softmax normalisation shifter. It divides an unsigned power-sum dividend by a power of two taken from a signed exponent, then saturates the result to the output width. Unlike the first-generation block, it applies real AXI-stream backpressure through a 2-stage pipeline. Rounding, bias and clamp are configurable, `tlast` passes through, and saturation is flagged and counted. It sits between the exponent/sum stage and the softmax output packer.

---
 rtl/div_softmax_pipe.sv | 125 ++++++++++++
 tb/tb_div_softmax_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_softmax_pipe.sv
// Softmax normalisation divider: dividend / 2^(exp - BIAS), saturated to OUT_W bits,
// behind a 2-stage AXI-stream pipeline with backpressure and a sticky saturation counter.
module div_softmax_pipe #(
    parameter int DIV_W      = 24,
    parameter int EXP_W      = 8,
    parameter int OUT_W      = 16,
    parameter int BIAS       = 4,
    parameter int EXP_MIN    = -12,
    parameter int MAX_RSHIFT = 4,
    parameter int ROUND_EN   = 0,
    parameter int CNT_W      = 16
) (
    input  logic               aclk,
    input  logic               rst,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [EXP_W-1:0]   s_exp,
    input  logic [DIV_W-1:0]   s_dividend,
    input  logic               s_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [OUT_W-1:0]   m_tdata,
    output logic               m_tlast,
    output logic               m_tsat,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   sat_cnt
);

    localparam int IW = DIV_W + BIAS - EXP_MIN;

    localparam logic signed [EXP_W:0] EMIN_S = (EXP_W+1)'(EXP_MIN);
    localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);
    localparam logic signed [EXP_W:0] MAXR_S = (EXP_W+1)'(MAX_RSHIFT);
    localparam logic signed [EXP_W:0] ZERO_S = '0;
    localparam logic [EXP_W:0]        ONE_U  = (EXP_W+1)'(1);

    logic               v1_q, v2_q;
    logic [IW-1:0]      d1_q;
    logic               last1_q;
    logic [OUT_W-1:0]   tdata_q;
    logic               tlast_q;
    logic               tsat_q;
    logic [CNT_W-1:0]   sat_cnt_q;

    logic               adv1, adv2;
    logic signed [EXP_W:0] exp_ext, e_eff;
    logic [EXP_W:0]     rsh, lsh;
    logic [IW-1:0]      div_ext, rnd, shift_d;
    logic               sat_d;
    logic [OUT_W-1:0]   tdata_d;
    logic [CNT_W-1:0]   sat_cnt_d;

    assign adv2     = !v2_q || m_tready;
    assign adv1     = !v1_q || adv2;
    assign s_tready = adv1;

    // Stage 1: clamp/bias the exponent and apply the shift; one of rsh/lsh is always zero.
    always_comb begin
        exp_ext = {s_exp[EXP_W-1], s_exp};
        e_eff   = (exp_ext <= EMIN_S) ? (EMIN_S - BIAS_S) : (exp_ext - BIAS_S);
        div_ext = IW'(s_dividend);
        rsh     = '0;
        lsh     = '0;
        if (e_eff > MAXR_S) begin
            rsh = MAXR_S;
        end else if (e_eff > ZERO_S) begin
            rsh = e_eff;
        end else begin
            lsh = -e_eff;
        end
        rnd = '0;
        if (ROUND_EN != 0 && rsh != '0) begin
            rnd = IW'(1) << (rsh - ONE_U);
        end
        shift_d = ((div_ext + rnd) >> rsh) << lsh;
    end

    // Stage 2: any bit above the output width means saturation.
    always_comb begin
        sat_d   = |d1_q[IW-1:OUT_W];
        tdata_d = sat_d ? {OUT_W{1'b1}} : d1_q[OUT_W-1:0];
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clr_stats) begin
            sat_cnt_d = '0;
        end else if (m_tvalid && m_tready && m_tsat && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            d1_q      <= '0;
            last1_q   <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            tsat_q    <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (adv1) begin
                v1_q    <= s_tvalid;
                d1_q    <= shift_d;
                last1_q <= s_tlast;
            end
            if (adv2) begin
                v2_q    <= v1_q;
                tdata_q <= tdata_d;
                tlast_q <= last1_q;
                tsat_q  <= sat_d;
            end
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign m_tvalid = v2_q;
    assign m_tdata  = tdata_q;
    assign m_tlast  = tlast_q;
    assign m_tsat   = tsat_q;
    assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_div_softmax_pipe.sv
// Directed bench for div_softmax_pipe: three instances (default, rounding, 2-bit counter)
// share one stimulus stream; outputs are compared against hand-computed values.
module tb_div_softmax_pipe;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [7:0]  s_exp = '0;
    logic [23:0] s_dividend = '0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b1;
    logic        clr_stats = 1'b0;

    logic        s_tready0, m_tvalid0, m_tlast0, m_tsat0;
    logic [15:0] m_tdata0, sat_cnt0;
    logic        s_tready_r, m_tvalid_r, m_tlast_r, m_tsat_r;
    logic [15:0] m_tdata_r, sat_cnt_r;
    logic        s_tready_c, m_tvalid_c, m_tlast_c, m_tsat_c;
    logic [15:0] m_tdata_c;
    logic [1:0]  sat_cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    div_softmax_pipe dut0 (
        .aclk(aclk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready0),
        .s_exp(s_exp), .s_dividend(s_dividend), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid0), .m_tready(m_tready), .m_tdata(m_tdata0),
        .m_tlast(m_tlast0), .m_tsat(m_tsat0), .clr_stats(clr_stats), .sat_cnt(sat_cnt0)
    );

    div_softmax_pipe #(.ROUND_EN(1)) dut_r (
        .aclk(aclk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready_r),
        .s_exp(s_exp), .s_dividend(s_dividend), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid_r), .m_tready(m_tready), .m_tdata(m_tdata_r),
        .m_tlast(m_tlast_r), .m_tsat(m_tsat_r), .clr_stats(clr_stats), .sat_cnt(sat_cnt_r)
    );

    div_softmax_pipe #(.CNT_W(2)) dut_c (
        .aclk(aclk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready_c),
        .s_exp(s_exp), .s_dividend(s_dividend), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid_c), .m_tready(m_tready), .m_tdata(m_tdata_c),
        .m_tlast(m_tlast_c), .m_tsat(m_tsat_c), .clr_stats(clr_stats), .sat_cnt(sat_cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One isolated beat with m_tready high: present, then check 2 edges later, then hand off.
    task automatic beat(input string tag, input logic [7:0] e, input logic [23:0] d,
                        input logic l, input logic [15:0] exp0, input logic [15:0] expr,
                        input logic sat);
        s_tvalid = 1'b1; s_exp = e; s_dividend = d; s_tlast = l;
        tick();
        s_tvalid = 1'b0;
        chk({tag, "_lat1_valid"}, 32'(m_tvalid0), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(m_tvalid0), 32'd1);
        chk({tag, "_data"}, 32'(m_tdata0), 32'(exp0));
        chk({tag, "_data_round"}, 32'(m_tdata_r), 32'(expr));
        chk({tag, "_sat"}, 32'(m_tsat0), 32'(sat));
        chk({tag, "_last"}, 32'(m_tlast0), 32'(l));
        $display("beat %s exp=%0d div=0x%0h -> data=0x%0h round=0x%0h sat=%0b last=%0b",
                 tag, $signed(e), d, m_tdata0, m_tdata_r, m_tsat0, m_tlast0);
        tick();
    endtask

    logic [31:0] pat = 32'b1100_0010_0111_0001_1011_0000_1110_0101;
    logic [15:0] exp_q[$];
    logic        explast_q[$];
    logic [15:0] want_d, held_d;
    logic        want_l, held_l, held_v;
    int          sent, recv, inflight;

    initial begin
        // Reset state; s_tready is high even with m_tready low since both stages are empty.
        m_tready = 1'b0;
        tick(); tick();
        chk("rst_m_tvalid", 32'(m_tvalid0), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata0), 32'd0);
        chk("rst_m_tsat", 32'(m_tsat0), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt0), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_s_tready", 32'(s_tready0), 32'd1);
        m_tready = 1'b1;

        beat("e0",    8'd0,   24'h000100, 1'b0, 16'h1000, 16'h1000, 1'b0);
        beat("e10",   8'd10,  24'h000100, 1'b1, 16'h0010, 16'h0010, 1'b0);
        beat("e5",    8'd5,   24'h000100, 1'b0, 16'h0080, 16'h0080, 1'b0);
        beat("rnd28", 8'd7,   24'd28,     1'b1, 16'd3,    16'd4,    1'b0);
        beat("zero",  8'h80,  24'h000000, 1'b0, 16'h0000, 16'h0000, 1'b0);

        chk("cnt_before_sat", 32'(sat_cnt0), 32'd0);
        beat("sat",   8'hEC,  24'h000100, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        chk("cnt_after_sat", 32'(sat_cnt0), 32'd1);

        // Clear coinciding with a saturated output handshake: clear wins.
        s_tvalid = 1'b1; s_exp = 8'hEC; s_dividend = 24'h000100; s_tlast = 1'b0;
        tick();
        s_tvalid = 1'b0;
        tick();
        chk("clr_beat_sat", 32'(m_tsat0), 32'd1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_wins", 32'(sat_cnt0), 32'd0);
        $display("clr with saturated beat -> sat_cnt=%0d", sat_cnt0);

        beat("ffffff", 8'd8, 24'hFFFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        chk("cnt_ffffff", 32'(sat_cnt_r), 32'd1);

        // Counter stickiness: five saturated beats back to back.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        s_tvalid = 1'b1; s_exp = 8'hEC; s_dividend = 24'h000100;
        repeat (5) tick();
        s_tvalid = 1'b0;
        repeat (4) tick();
        chk("cnt16_five", 32'(sat_cnt0), 32'd5);
        chk("cnt2_sticks", 32'(sat_cnt_c), 32'd3);
        $display("5 saturated beats -> sat_cnt16=%0d sat_cnt2=%0d", sat_cnt0, sat_cnt_c);

        // Backpressure stream: 8 beats, bubbles on input, pseudo-random m_tready.
        sent = 0; recv = 0; inflight = 0; held_v = 1'b0; held_d = '0; held_l = 1'b0;
        for (int c = 0; c < 300 && recv < 8; c++) begin
            m_tready = pat[c % 32];
            if (sent < 8 && (c % 5) != 3) begin
                s_tvalid = 1'b1; s_exp = 8'd0;
                s_dividend = 24'h000100 + 24'(sent);
                s_tlast = (sent == 3 || sent == 7);
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            chk("bp_s_tready", 32'(s_tready0), 32'(!(inflight == 2 && !m_tready)));
            if (held_v) begin
                chk("bp_hold_valid", 32'(m_tvalid0), 32'd1);
                chk("bp_hold_data", 32'(m_tdata0), 32'(held_d));
                chk("bp_hold_last", 32'(m_tlast0), 32'(held_l));
            end
            if (s_tvalid && s_tready0) begin
                exp_q.push_back(16'h1000 + 16'(16 * sent));
                explast_q.push_back(s_tlast);
                sent++;
                inflight++;
            end
            if (m_tvalid0 && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_beat", 32'(m_tdata0), 32'hFFFF_FFFF);
                end else begin
                    want_d = exp_q.pop_front();
                    want_l = explast_q.pop_front();
                    chk("bp_data", 32'(m_tdata0), 32'(want_d));
                    chk("bp_last", 32'(m_tlast0), 32'(want_l));
                    $display("bp beat %0d data=0x%0h last=%0b (cycle %0d)", recv, m_tdata0, m_tlast0, c);
                end
                recv++;
                inflight--;
            end
            held_v = m_tvalid0 && !m_tready;
            held_d = m_tdata0;
            held_l = m_tlast0;
            tick();
        end
        s_tvalid = 1'b0;
        chk("bp_beats_received", 32'(recv), 32'd8);

        // Reset with two beats in flight.
        m_tready = 1'b0;
        s_tvalid = 1'b1; s_exp = 8'hEC; s_dividend = 24'h000100;
        tick(); tick();
        s_tvalid = 1'b0;
        chk("mid_rst_inflight", 32'(m_tvalid0), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(m_tvalid0), 32'd0);
        chk("mid_rst_cnt", 32'(sat_cnt0), 32'd0);
        $display("reset mid-stream -> m_tvalid=%0b sat_cnt=%0d", m_tvalid0, sat_cnt0);
        rst = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_stale", 32'(m_tvalid0), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
